aw_engine: RTL
==============

// Module: aw_engine
// PURPOSE
// Write-address stage of the DMA write path. It splits one write request
// (start address, byte count) into AXI4 INCR bursts. Each burst is capped at
// MAX_BURST_LEN beats and never crosses a 4KB boundary. Bursts are issued on
// the AW channel, and a matching beat count goes to the W engine. Each accepted
// AW is reported to the downstream B-response engine via new_transaction, and
// the final burst also via last_transaction.
// PARAMETERS
// AXI_DATA_WIDTH  64  data bus width in bits; BEAT_BYTES = AXI_DATA_WIDTH/8
// AXI_ADDR_WIDTH  64  AXI address width in bits
// BTT_WIDTH       23  width of the bytes-to-transfer request field
// MAX_BURST_LEN   256 max beats per burst, 1..256
// PORTS
// clk              in   1    clock
// rstn             in   1    reset, synchronous, active-low
// start            in   1    1-cycle request strobe; sampled only in IDLE
// addr             in   AXI_ADDR_WIDTH  start address, BEAT_BYTES-aligned
// btt              in   BTT_WIDTH       bytes to transfer, multiple of BEAT_BYTES
// busy             out  1    high whenever state != IDLE
// new_transaction  out  1    1-cycle pulse on each AW handshake
// last_transaction out  1    same-cycle qualifier: the accepted AW is the final burst
// wcmd_valid       out  1    W-engine command valid
// wcmd_ready       in   1    W-engine command ready
// wcmd_beats       out  9    beats in the burst, 1..256
// aw_chan          AXI4_AW.master  awid=0, awsize=log2(BEAT_BYTES), awburst=INCR,
//                   awcache/awprot/awlock/awqos=0
// BEHAVIOUR
// - Reset (rstn=0 at a clk edge): state=IDLE; awvalid, wcmd_valid, busy,
//   new_transaction and last_transaction all 0. Reset has priority at any time;
//   mid-burst abort is allowed because the whole DMA resets together.
// - LOW = log2(BEAT_BYTES). remaining (BTT_WIDTH-LOW bits) = btt>>LOW at start.
// - IDLE: on start, latch addr and remaining, go to CALC. If btt>>LOW == 0,
//   stay IDLE and emit no pulses.
// - CALC (1 cycle):
//   - to4k = (4096 - addr[11:0]) >> LOW, giving 1..4096/BEAT_BYTES.
//   - beats = min(remaining, MAX_BURST_LEN, to4k).
//   - awaddr = addr; awlen = beats-1; wcmd_beats = beats;
//     is_last = (beats == remaining).
//   - Go to ISSUE.
// - ISSUE:
//   - awvalid and wcmd_valid both rise on ISSUE entry. Each is held, with
//     stable payload, until its own handshake, then drops.
//   - Per-channel done flags track completion. The handshakes may occur in the
//     same cycle or in either order.
//   - On the AW handshake cycle: new_transaction=1, last_transaction=is_last.
//   - When both channels are done: addr += beats<<LOW; remaining -= beats.
//     Then go to IDLE if remaining==0, else to CALC.
//   - ISSUE->CALC->ISSUE costs one idle cycle per burst.
// - start while busy is ignored; no queuing.
// - Latency: start to first awvalid = 2 cycles (IDLE->CALC->ISSUE).
// - Address arithmetic wraps at AXI_ADDR_WIDTH; the caller must not wrap.
// - The 4KB split takes precedence over MAX_BURST_LEN: a split burst may be
//   shorter than both the cap and remaining.
// TESTING
// - addr=0x1000, btt=8 -> one AW: awaddr=0x1000, awlen=0; wcmd_beats=1;
//   new_transaction and last_transaction both pulse once.
// - addr=0x0FF0, btt=64 -> AW 0x0FF0 len=1, then AW 0x1000 len=5;
//   last_transaction only on the second burst.
// - addr=0, btt=4096, MAX_BURST_LEN=256 -> 2 bursts of 256 beats (len=255);
//   no 4KB split.
// - Backpressure: awready held low 5 cycles, wcmd_ready given first ->
//   awvalid and payload stay stable; new_transaction pulses exactly once;
//   the next burst waits for both handshakes.
// - start pulsed during ISSUE -> ignored; burst count and addresses unchanged.
// - rstn low mid-ISSUE -> next cycle awvalid=0, wcmd_valid=0, busy=0; a fresh
//   start then behaves as from power-up.

Source files
------------

// File: rtl/aw_engine_if.sv
// AXI4 write-address channel bundle; the engine drives it through the master modport.
interface AXI4_AW #(
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 1
);
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic                  awvalid;
  logic                  awready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready
  );
endinterface

// File: rtl/aw_engine.sv
// DMA write-address stage: splits (addr, btt) into AXI4 INCR bursts capped at
// MAX_BURST_LEN beats and 4KB boundaries, with a matching beat count to the W engine.
module aw_engine #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int BTT_WIDTH      = 23,
  parameter int MAX_BURST_LEN  = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [BTT_WIDTH-1:0]      btt,
  output logic                      busy,
  output logic                      new_transaction,
  output logic                      last_transaction,
  output logic                      wcmd_valid,
  input  logic                      wcmd_ready,
  output logic [8:0]                wcmd_beats,
  AXI4_AW.master                    aw_chan
);
  localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
  localparam int LOW        = $clog2(BEAT_BYTES);
  localparam int RW         = BTT_WIDTH - LOW;
  localparam int CW         = (RW > 13) ? RW : 13;

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} state_t;
  typedef struct packed {
    logic [8:0] beats;
    logic       last;
  } burst_t;

  state_t                    state, state_n;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]             rem_q;
  burst_t                    cur;
  logic                      aw_done, w_done;

  logic [12:0]   to4k;
  logic [CW-1:0] rem_x, cap_x, t4_x, beats_c;
  logic          aw_hs, w_hs, both_done;

  // Beats left before the next 4KB boundary; never zero since addr is beat-aligned.
  assign to4k  = (13'h1000 - {1'b0, addr_q[11:0]}) >> LOW;
  assign rem_x = CW'(rem_q);
  assign cap_x = CW'(MAX_BURST_LEN);
  assign t4_x  = CW'(to4k);

  always_comb begin
    beats_c = rem_x;
    if (cap_x < beats_c) beats_c = cap_x;
    if (t4_x < beats_c)  beats_c = t4_x;
  end

  assign aw_chan.awvalid = (state == ISSUE) && !aw_done;
  assign wcmd_valid      = (state == ISSUE) && !w_done;
  assign aw_hs           = aw_chan.awvalid && aw_chan.awready;
  assign w_hs            = wcmd_valid && wcmd_ready;
  // Either channel may complete first; the burst retires once both have.
  assign both_done       = (aw_done || aw_hs) && (w_done || w_hs);

  assign busy             = (state != IDLE);
  assign new_transaction  = aw_hs;
  assign last_transaction = aw_hs && cur.last;
  assign wcmd_beats       = cur.beats;

  assign aw_chan.awid    = '0;
  assign aw_chan.awaddr  = addr_q;
  assign aw_chan.awlen   = 8'(cur.beats - 9'd1);
  assign aw_chan.awsize  = 3'(LOW);
  assign aw_chan.awburst = 2'b01;
  assign aw_chan.awlock  = 1'b0;
  assign aw_chan.awcache = 4'd0;
  assign aw_chan.awprot  = 3'd0;
  assign aw_chan.awqos   = 4'd0;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start && (btt[BTT_WIDTH-1:LOW] != '0)) state_n = CALC;
      CALC:    state_n = ISSUE;
      ISSUE:   if (both_done) state_n = (rem_q == RW'(cur.beats)) ? IDLE : CALC;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cur     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (start) begin
          addr_q <= addr;
          rem_q  <= btt[BTT_WIDTH-1:LOW];
        end
        CALC: begin
          cur.beats <= beats_c[8:0];
          cur.last  <= (beats_c == rem_x);
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
        end
        ISSUE: begin
          if (both_done) begin
            addr_q  <= addr_q + (AXI_ADDR_WIDTH'(cur.beats) << LOW);
            rem_q   <= rem_q - RW'(cur.beats);
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
